// File: rtl/mf_cebridge_multi_if.sv
// Configuration and strobe bundle for mf_cebridge_multi.
// The master drives configuration requests; the slave returns handshake, error, enables and lock.
interface mf_cebridge_multi_if #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned RATIO_W = 16
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [2:0]          cfg_chan;
    logic [RATIO_W-1:0]  cfg_num;
    logic [RATIO_W-1:0]  cfg_den;
    logic                cfg_err;
    logic [NUM_CH-1:0]   outclk_en;
    logic                locked;

    modport master (
        output cfg_valid, cfg_chan, cfg_num, cfg_den,
        input  cfg_ready, cfg_err, outclk_en, locked
    );

    modport slave (
        input  cfg_valid, cfg_chan, cfg_num, cfg_den,
        output cfg_ready, cfg_err, outclk_en, locked
    );
endinterface

// File: rtl/mf_cebridge_multi.sv
// Multi-channel fractional clock-enable generator: each channel strobes at refclk * num/den,
// all channels phase-aligned by a shared lock counter that restarts on every reconfiguration.
module mf_cebridge_multi #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned RATIO_W     = 16,
    parameter int unsigned INIT_NUM    = 140,
    parameter int unsigned INIT_DEN    = 363,
    parameter int unsigned LOCK_CYCLES = 1024
) (
    input logic               refclk,
    input logic               rst,
    mf_cebridge_multi_if.slave cfg
);
    localparam int unsigned CntW = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;

    logic [RATIO_W-1:0] num_q [NUM_CH];
    logic [RATIO_W-1:0] num_d [NUM_CH];
    logic [RATIO_W-1:0] den_q [NUM_CH];
    logic [RATIO_W-1:0] den_d [NUM_CH];
    logic [RATIO_W:0]   acc_q [NUM_CH];
    logic [RATIO_W:0]   acc_d [NUM_CH];
    logic [NUM_CH-1:0]  en_q, en_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               locked_q, locked_d;
    logic               ready_q, ready_d;
    logic               err_q, err_d;

    logic req_fire;
    logic req_bad;

    assign req_fire = cfg.cfg_valid & ready_q;
    assign req_bad  = (cfg.cfg_den == '0) || (cfg.cfg_num >= cfg.cfg_den) ||
                      (32'(cfg.cfg_chan) >= NUM_CH);

    always_comb begin
        logic [RATIO_W:0] sum;
        sum      = '0;
        cnt_d    = cnt_q;
        locked_d = locked_q;
        ready_d  = 1'b1;
        err_d    = 1'b0;
        en_d     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            num_d[i] = num_q[i];
            den_d[i] = den_q[i];
            acc_d[i] = '0;
        end

        // Normal progression; a rejected request leaves this untouched.
        if (!locked_q) begin
            if (cnt_q == CntW'(LOCK_CYCLES - 1)) begin
                locked_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                sum = acc_q[i] + {1'b0, num_q[i]};
                if (sum >= {1'b0, den_q[i]}) begin
                    acc_d[i] = sum - {1'b0, den_q[i]};
                    en_d[i]  = 1'b1;
                end else begin
                    acc_d[i] = sum;
                end
            end
        end

        if (req_fire && req_bad) begin
            err_d = 1'b1;
        end else if (req_fire) begin
            // Accepted ratio change restarts lock so every channel realigns together.
            for (int i = 0; i < NUM_CH; i++) begin
                if (32'(cfg.cfg_chan) == i) begin
                    num_d[i] = cfg.cfg_num;
                    den_d[i] = cfg.cfg_den;
                end
                acc_d[i] = '0;
            end
            en_d     = '0;
            locked_d = 1'b0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                num_q[i] <= RATIO_W'(INIT_NUM);
                den_q[i] <= RATIO_W'(INIT_DEN);
                acc_q[i] <= '0;
            end
            en_q     <= '0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                num_q[i] <= num_d[i];
                den_q[i] <= den_d[i];
                acc_q[i] <= acc_d[i];
            end
            en_q     <= en_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
        end
    end

    assign cfg.outclk_en = en_q;
    assign cfg.locked    = locked_q;
    assign cfg.cfg_ready = ready_q;
    assign cfg.cfg_err   = err_q;
endmodule

// File: doc/mf_cebridge_multi.md
Name: mf_cebridge_multi

Overview:
- Multi-channel fractional clock-enable generator, the parametrised successor to the single-output PLL wrapper.
- From one reference clock it produces NUM_CH independent, phase-aligned clock-enable strobes, each at rate refclk × NUM/DEN.
- Each channel's ratio is reconfigurable at runtime through a valid/ready port.
- A PLL-style `locked` flag qualifies the outputs after reset and after every reconfiguration.
- Sits beside the core PLL to derive CPU, video and audio enables that a hard PLL cannot synthesise exactly.

Parameters:
- NUM_CH, 2: number of enable channels (1..8).
- RATIO_W, 16: width of the NUM and DEN ratio terms.
- INIT_NUM, 140: reset numerator, applied to all channels.
- INIT_DEN, 363: reset denominator, applied to all channels (74.25 MHz × 140/363 = 28.636363 MHz).
- LOCK_CYCLES, 1024: settle time, in refclk cycles, before `locked` asserts (≥2).

Ports:
- refclk  in  1  sole clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration accept; the handshake completes when cfg_valid & cfg_ready.
- cfg_chan  in  3  target channel index.
- cfg_num  in  RATIO_W  new numerator.
- cfg_den  in  RATIO_W  new denominator.
- cfg_err  out  1  one-cycle pulse when an accepted request is rejected.
- outclk_en  out  NUM_CH  per-channel one-cycle enable strobes.
- locked  out  1  enables are valid and phase-aligned.

Behaviour:
- Reset values (synchronous, refclk edge with rst=1):
  - outclk_en=0, locked=0, cfg_err=0, cfg_ready=0.
  - All accumulators = 0; num[i]=INIT_NUM, den[i]=INIT_DEN; lock counter = 0.
- cfg_ready = 1 in every cycle after reset is released; it is registered as !rst.
- Lock counter:
  - Increments each cycle while locked=0.
  - When the counter equals LOCK_CYCLES-1, locked is set at the next edge and the counter holds.
  - locked is therefore first high exactly LOCK_CYCLES cycles after rst deasserts.
- Accumulator, per channel, RATIO_W+1 bits unsigned, computed in every cycle with locked=1:
  - sum = acc + num[i].
  - If sum ≥ den[i]: acc ← sum − den[i] and outclk_en[i] ← 1.
  - Otherwise: acc ← sum and outclk_en[i] ← 0.
- While locked=0, accumulators are held at 0 and outclk_en=0.
- Consequences:
  - All channels start in the same cycle, so they are phase-aligned.
  - Each channel gives exactly num pulses per den locked cycles, with no long-term drift.
  - The strobe is registered: overflow computed in cycle k → outclk_en high in cycle k+1.
  - num ≥ den never occurs, so there is never more than one pulse per cycle.
- Config validation on handshake. A request is rejected when any of:
  - cfg_den == 0;
  - cfg_num ≥ cfg_den;
  - cfg_chan ≥ NUM_CH.
- On rejection:
  - cfg_err=1 for the next cycle only.
  - No state changes; locked and the accumulators continue undisturbed.
- On a valid request, at the next edge:
  - num/den of cfg_chan are updated.
  - locked ← 0, lock counter ← 0, every accumulator ← 0, outclk_en ← 0.
  - Relock follows after LOCK_CYCLES and realigns all channels.
- cfg_num = 0 is valid and gives a silent channel (outclk_en stays 0).
- Back-to-back valid requests are each accepted, and each restarts the lock counter from 0.
- A request in the same cycle as rst=1 is ignored; reset wins.
- rst asserted mid-operation restores all reset values at that edge, including the INIT ratios. Runtime configuration is lost.

Test Plan:
- Reset default, NUM_CH=2: release rst → locked rises after exactly 1024 cycles; first outclk_en pulses on both channels 3 cycles after locked; exactly 140 pulses per 363-cycle window on each channel, over 10 windows.
- Reconfigure ch1 to 1/2 while locked → locked drops the next cycle; both enables = 0 for 1024 cycles; then ch1 toggles every other cycle, ch0 resumes 140/363, first pulses aligned relative to the new locked edge.
- Invalid requests (den=0; num=5/den=5; chan=2 with NUM_CH=2) → cfg_err single-cycle pulse each; locked stays 1; pulse counts unchanged.
- Edge ratios: num=0 → no pulses over 2000 cycles; num=65534/den=65535 → exactly one missing pulse per 65535 cycles.
- rst asserted 500 cycles after a reconfig and mid-lock → all outputs 0 next edge; after release, ch1 is back at 140/363 and locked returns after 1024 cycles.
- cfg_valid together with rst=1 → no cfg_err and no ratio change after reset.
